// File: rtl/voter_tally.sv
// Weighted ballot tally: three voter classes are popcounted, weighted and summed
// into a saturating accumulator, with an IDLE/OPEN/CLOSED round controller.
module voter_tally #(
    parameter int NP_W    = 32,
    parameter int VIP_W   = 8,
    parameter int VVIP_W  = 1,
    parameter int NP_WT   = 1,
    parameter int VIP_WT  = 4,
    parameter int VVIP_WT = 16,
    parameter int RES_W   = 8,
    parameter int THRESH  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              close,
    input  logic              in_valid,
    input  logic [NP_W-1:0]   np,
    input  logic [VIP_W-1:0]  vip,
    input  logic [VVIP_W-1:0] vvip,
    output logic [RES_W-1:0]  result,
    output logic              sat,
    output logic              done,
    output logic              pass
);

    localparam int W_MAX  = NP_W * NP_WT + VIP_W * VIP_WT + VVIP_W * VVIP_WT;
    localparam int SUM_W  = $clog2(W_MAX + 1);
    // One spare bit above the wider operand so result+W can never wrap.
    localparam int ACC_W  = ((RES_W > SUM_W) ? RES_W : SUM_W) + 1;
    localparam int CMP_W  = (RES_W > 31) ? RES_W + 1 : 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_CLOSED
    } state_e;

    state_e             state_q, state_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               sat_q, sat_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W-1:0]   acc_sum;
    logic               acc_ovf;
    logic [RES_W-1:0]   acc_clamp;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NP_W; i++) begin
            if (np[i]) w_sum = w_sum + ACC_W'(NP_WT);
        end
        for (int i = 0; i < VIP_W; i++) begin
            if (vip[i]) w_sum = w_sum + ACC_W'(VIP_WT);
        end
        for (int i = 0; i < VVIP_W; i++) begin
            if (vvip[i]) w_sum = w_sum + ACC_W'(VVIP_WT);
        end
    end

    // A start discards the old tally, so the same-edge vote adds to zero.
    always_comb begin
        acc_base  = start ? '0 : {{(ACC_W - RES_W){1'b0}}, result_q};
        acc_sum   = acc_base + (in_valid ? w_sum : '0);
        acc_ovf   = |acc_sum[ACC_W-1:RES_W];
        acc_clamp = acc_ovf ? {RES_W{1'b1}} : acc_sum[RES_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        sat_d    = sat_q;
        done_d   = done_q;
        pass_d   = pass_q;
        if (start) begin
            state_d  = S_OPEN;
            result_d = acc_clamp;
            sat_d    = acc_ovf;
            done_d   = 1'b0;
            pass_d   = 1'b0;
        end else begin
            case (state_q)
                S_OPEN: begin
                    result_d = acc_clamp;
                    sat_d    = sat_q | acc_ovf;
                    if (close) begin
                        state_d = S_CLOSED;
                        done_d  = 1'b1;
                        pass_d  = CMP_W'(acc_clamp) >= CMP_W'(THRESH);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            sat_q    <= sat_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign result = result_q;
    assign sat    = sat_q;
    assign done   = done_q;
    assign pass   = pass_q;

endmodule

// File: doc/voter_tally.md
VOTER_TALLY -- requirements
Module: voter_tally

Interface
REQ-001 The module SHALL have parameter NP_W, default 32, meaning number of normal-voter ballot bits.
REQ-002 The module SHALL have parameter VIP_W, default 8, meaning number of VIP ballot bits.
REQ-003 The module SHALL have parameter VVIP_W, default 1, meaning number of VVIP ballot bits.
REQ-004 The module SHALL have parameters NP_WT, VIP_WT and VVIP_WT, defaults 1, 4 and 16, meaning the per-bit vote weight of each class.
REQ-005 The module SHALL have parameter RES_W, default 8, meaning tally width.
REQ-006 The module SHALL have parameter THRESH, default 128, meaning the minimum tally for a pass decision.
REQ-007 The module SHALL have port clk, input, width 1, the single clock; all state SHALL update on the rising edge.
REQ-008 The module SHALL have port reset, input, width 1; reset is asynchronous and active-high.
REQ-009 The module SHALL have port start, input, width 1, meaning open a new ballot round.
REQ-010 The module SHALL have port close, input, width 1, meaning end the current round.
REQ-011 The module SHALL have port in_valid, input, width 1, meaning the ballot inputs are valid this cycle.
REQ-012 The module SHALL have ports np, vip and vvip, inputs, widths NP_W, VIP_W and VVIP_W, meaning one bit per voter with 1 = yes.
REQ-013 The module SHALL have port result, output, width RES_W, meaning the running weighted tally.
REQ-014 The module SHALL have port sat, output, width 1, meaning the tally has saturated in this round (sticky).
REQ-015 The module SHALL have port done, output, width 1, meaning the round is closed and the decision is valid.
REQ-016 The module SHALL have port pass, output, width 1, meaning the decision, defined as result >= THRESH, valid while done=1.

Function
REQ-017 The block SHALL implement a 3-state FSM: IDLE, OPEN and CLOSED.
REQ-018 On reset the FSM SHALL enter IDLE, with result=0, sat=0, done=0 and pass=0.
REQ-019 Weighted sum per cycle:
- W = NP_WT·popcount(np) + VIP_WT·popcount(vip) + VVIP_WT·popcount(vvip).
- W SHALL be computed at a width wide enough that W never overflows internally.
REQ-020 IDLE transitions:
- start=1 moves the FSM to OPEN and clears result and sat.
- in_valid and close SHALL be ignored.
REQ-021 OPEN accumulation: in_valid=1 SHALL set result to min(result+W, 2^RES_W−1) on that edge, a latency of 1 cycle.
- result SHALL be visible the cycle after the sampling edge.
REQ-022 sat SHALL be set when the unclamped result+W exceeds 2^RES_W−1, and SHALL stay set until the next start or reset.
REQ-023 OPEN with close=1 moves the FSM to CLOSED, and SHALL register done=1 and pass=(final result >= THRESH).
- The final result SHALL include any in_valid vote sampled on the same edge.
REQ-024 CLOSED holding behaviour:
- result, sat and pass SHALL hold.
- in_valid and close SHALL be ignored.
- start=1 moves the FSM to OPEN, clears result, sat, done and pass.
REQ-025 start=1 in OPEN SHALL restart the round: result and sat are cleared and the FSM stays in OPEN.
REQ-026 Simultaneous start and close SHALL be resolved as start wins in every state.
REQ-027 start together with in_valid in IDLE, OPEN or CLOSED SHALL load result with min(W, 2^RES_W−1), i.e. the clear and the first vote happen on the same edge.
- sat SHALL be set if W alone exceeds the maximum.
REQ-028 done and pass SHALL be 0 in IDLE and OPEN.
REQ-029 pass SHALL use the saturated result value.
REQ-030 Outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-031 Asserting reset at any time, including mid-round, SHALL asynchronously force IDLE, result=0, sat=0, done=0 and pass=0 without waiting for a clock edge.
REQ-032 After reset deasserts, no vote SHALL be counted until a start is sampled.

Verification
REQ-033 Single-ballot test (defaults): reset, then start, then in_valid with np=32'hFFFFFFF0, vip=8'b1101_0101, vvip=0 -> result=48 one cycle later, sat=0.
REQ-034 Two-ballot accumulation test:
- Continue from REQ-033 with in_valid, np=32'h0000000F, vip=8'b0010_1010, vvip=1 -> result=80.
- Then close -> done=1, pass=0, and result holds 80 on later in_valid pulses.
REQ-035 Saturation test: start, then 4 in_valid cycles with all inputs all-ones (W=80 each) -> result 80, 160, 240, then 255 with sat=1; then close -> pass=1.
REQ-036 Same-edge close test: in OPEN with result=100, drive in_valid (W=32) together with close -> result=132, done=1, pass=1.
- A following start together with in_valid (W=16) -> OPEN, result=16, done=0, sat=0.
REQ-037 Mid-round reset and start-priority test:
- In OPEN with result nonzero, pulse reset between clock edges -> outputs go to 0 immediately, and a later in_valid without start leaves result=0.
- start together with close in OPEN -> FSM stays OPEN and result=0.
